// File: rtl/inst_prefetch_queue.sv
// In-order instruction prefetch queue: head valid one cycle after the IMEM response; redirects flush and drop stale responses.
// Backpressure: i_ready=0 holds the head; issue stops once buffered plus live in-flight entries would exceed DEPTH.
module inst_prefetch_queue #(
   parameter int              XLEN            = 32,
   parameter int              DEPTH           = 4,
   parameter int              MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_VECTOR    = '0
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_trap_req,
   input  logic [XLEN-1:0] i_mtvec,
   input  logic            i_trap_mret,
   input  logic [XLEN-1:0] i_mepc,
   input  logic            i_take_branch,
   input  logic [XLEN-1:0] i_new_addr,
   output logic            o_imem_req_valid,
   input  logic            i_imem_req_ready,
   output logic [XLEN-1:0] o_imem_req_addr,
   input  logic            i_imem_rsp_valid,
   input  logic [XLEN-1:0] i_imem_rsp_data,
   input  logic            i_imem_rsp_err,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_pc_4,
   output logic [XLEN-1:0] o_inst,
   output logic            o_t_inst_addr_misaligned,
   output logic            o_t_inst_access_fault
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int SW = CW + OW;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic            mis;
      logic            fault;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [OW-1:0]   outstanding_q, outstanding_d;
   logic [OW-1:0]   drop_q, drop_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
   logic            halted_q, halted_d;

   logic            redirect;
   logic [XLEN-1:0] target;
   logic [SW-1:0]   credit_used;
   logic            req_fire;
   logic            head_vld;
   logic            pop;
   logic            push;
   entry_t          head;

   assign redirect = i_trap_req | i_trap_mret | i_take_branch;
   assign target   = i_trap_req  ? i_mtvec :
                     i_trap_mret ? i_mepc  : i_new_addr;

   // Live in-flight responses (outstanding minus those already doomed) reserve a slot each.
   assign credit_used = SW'(count_q) + SW'(outstanding_q) - SW'(drop_q);

   assign o_imem_req_valid = i_rst && !halted_q && !redirect &&
                             (outstanding_q < OW'(MAX_OUTSTANDING)) &&
                             (credit_used < SW'(DEPTH));
   assign o_imem_req_addr  = i_rst ? fetch_pc_q : '0;
   assign req_fire         = o_imem_req_valid && i_imem_req_ready;

   assign head_vld = (count_q != '0);
   assign head     = mem_q[rd_ptr_q];
   assign pop      = head_vld && i_ready;

   assign o_valid                  = head_vld;
   assign o_pc                     = head_vld ? head.pc : '0;
   assign o_pc_4                   = head_vld ? head.pc + XLEN'(4) : '0;
   assign o_inst                   = head_vld ? head.inst : '0;
   assign o_t_inst_addr_misaligned = head_vld && head.mis;
   assign o_t_inst_access_fault    = head_vld && head.fault;

   always_comb begin
      mem_d         = mem_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      drop_d        = drop_q;
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      halted_d      = halted_q;
      push          = 1'b0;
      outstanding_d = outstanding_q + OW'(req_fire) - OW'(i_imem_rsp_valid);

      if (redirect) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         drop_d     = outstanding_d;
         fetch_pc_d = target;
         rsp_pc_d   = target;
         halted_d   = 1'b0;
         if (target[1:0] != 2'b00) begin
            mem_d[0] = '{pc: target, inst: '0, mis: 1'b1, fault: 1'b0};
            wr_ptr_d = PW'(1);
            count_d  = CW'(1);
            halted_d = 1'b1;
         end
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (i_imem_rsp_valid) begin
            if (drop_q != '0) begin
               drop_d = drop_q - OW'(1);
            end else begin
               push            = 1'b1;
               mem_d[wr_ptr_q] = '{pc: rsp_pc_q,
                                   inst: i_imem_rsp_err ? '0 : i_imem_rsp_data,
                                   mis: 1'b0, fault: i_imem_rsp_err};
               wr_ptr_d        = wr_ptr_q + PW'(1);
               rsp_pc_d        = rsp_pc_q + XLEN'(4);
               if (i_imem_rsp_err) begin
                  halted_d = 1'b1;
                  drop_d   = outstanding_d;
               end
            end
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         outstanding_q <= '0;
         drop_q        <= '0;
         fetch_pc_q    <= RESET_VECTOR;
         rsp_pc_q      <= RESET_VECTOR;
         halted_q      <= 1'b0;
      end else begin
         mem_q         <= mem_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         halted_q      <= halted_d;
      end
   end

   a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst)
      !(push && !pop && count_q == CW'(DEPTH)));
   a_no_spurious_rsp: assert property (@(posedge i_clk) disable iff (!i_rst)
      !(i_imem_rsp_valid && outstanding_q == '0));

endmodule
